// File: rtl/cache_pkg.sv
// cache_pkg: address-field widths, FSM state encoding and memory opcode constants for set_assoc_cache.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, WB, FETCH, WAIT, FILL} state_t;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ = 1'b0;
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction
  function automatic int word_w(input int words);
    return $clog2(words);
  endfunction
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int addr_w, input int data_w, input int words, input int sets);
    return addr_w - off_w(data_w) - word_w(words) - idx_w(sets);
  endfunction
  function automatic int way_w(input int ways);
    return ways > 1 ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/cache_victim_sel.sv
// cache_victim_sel: picks the lowest invalid way, else the round-robin pointer, and flags a dirty victim.
module cache_victim_sel
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int PW = way_w(WAYS)
) (
  input  logic [WAYS-1:0] valid,
  input  logic [WAYS-1:0] dirty,
  input  logic [PW-1:0]   ptr,
  output logic [PW-1:0]   way,
  output logic            need_wb
);
  always_comb begin
    way = ptr;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w]) way = PW'(w);
    need_wb = valid[way] && dirty[way];
  end
endmodule

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-back, write-allocate cache with a valid/ready line memory port.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS = 2,
  parameter int SETS = 256,
  parameter int WORDS = 4,
  parameter int LINE_W = WORDS * DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              interface_ready,
  input  logic              rden,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata
);
  localparam int OW = off_w(DATA_W);
  localparam int WW = word_w(WORDS);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(ADDR_W, DATA_W, WORDS, SETS);
  localparam int PW = way_w(WAYS);
  localparam int WA = ADDR_W - OW;
  localparam int BW = OW + WW;

  logic [WAYS-1:0]   valid [SETS];
  logic [WAYS-1:0]   dirty [SETS];
  logic [PW-1:0]     ptr   [SETS];
  logic [TW-1:0]     tags  [WAYS][SETS];
  logic [LINE_W-1:0] lines [WAYS][SETS];

  state_t          state, state_next;
  logic [WA-1:0]   req_wa;
  logic [DATA_W-1:0] req_data;
  logic            req_wr;
  logic [PW-1:0]   req_way;

  logic [WA-1:0]   a_wa;
  logic [WW-1:0]   a_word;
  logic [IW-1:0]   a_idx, r_idx;
  logic [TW-1:0]   a_tag, r_tag;
  logic [DATA_W-1:0] a_data;
  logic            a_rd, a_wr, hit, miss, wr_hit, fill, vic_wb;
  logic [PW-1:0]   hit_way, vic_way, ptr_next;
  logic [LINE_W-1:0] hit_line;

  // FILL replays the latched request through the same lookup path as an IDLE hit
  assign a_wa   = state == FILL ? req_wa : addr_in[ADDR_W-1:OW];
  assign a_rd   = state == FILL ? !req_wr : state == IDLE && rden;
  assign a_wr   = state == FILL ? req_wr : state == IDLE && wren;
  assign a_data = state == FILL ? req_data : data_in;
  assign a_word = a_wa[WW-1:0];
  assign a_idx  = a_wa[WW +: IW];
  assign a_tag  = a_wa[WA-1 -: TW];
  assign r_idx  = req_wa[WW +: IW];
  assign r_tag  = req_wa[WA-1 -: TW];

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[a_idx][w] && tags[w][a_idx] == a_tag) begin
        hit = 1'b1;
        hit_way = PW'(w);
      end
  end

  assign hit_line        = lines[hit_way][a_idx];
  assign data_out        = hit_line[DATA_W*a_word +: DATA_W];
  assign data_out_valid  = a_rd && hit;
  assign wr_hit          = a_wr && hit;
  assign miss            = state == IDLE && (rden || wren) && !hit;
  assign interface_ready = state == FILL || (state == IDLE && !miss);

  cache_victim_sel #(.WAYS(WAYS), .PW(PW)) u_victim (
    .valid  (valid[a_idx]),
    .dirty  (dirty[a_idx]),
    .ptr    (ptr[a_idx]),
    .way    (vic_way),
    .need_wb(vic_wb)
  );

  assign mem_req_valid = state == WB || state == FETCH;
  assign mem_we        = state == WB ? MEM_WRITE : MEM_READ;
  assign mem_addr      = {state == WB ? tags[req_way][r_idx] : r_tag, r_idx, {BW{1'b0}}};
  assign mem_wdata     = lines[req_way][r_idx];
  assign fill          = mem_rvalid && (state == WAIT || (state == FETCH && mem_req_ready));
  assign ptr_next      = ptr[r_idx] == PW'(WAYS - 1) ? '0 : ptr[r_idx] + 1'b1;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (miss) state_next = vic_wb ? WB : FETCH;
      WB:      if (mem_req_ready) state_next = FETCH;
      FETCH:   if (mem_req_ready) state_next = mem_rvalid ? FILL : WAIT;
      WAIT:    if (mem_rvalid) state_next = FILL;
      FILL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_next;

  always_ff @(posedge clk)
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        ptr[s]   <= '0;
      end
    end else begin
      if (fill) begin
        valid[r_idx][req_way] <= 1'b1;
        dirty[r_idx][req_way] <= 1'b0;
        ptr[r_idx]            <= ptr_next;
      end
      if (wr_hit) dirty[a_idx][hit_way] <= 1'b1;
    end

  // Data and tag storage is deliberately not reset; valid bits guard it
  always_ff @(posedge clk) begin
    if (miss) begin
      req_wa   <= addr_in[ADDR_W-1:OW];
      req_data <= data_in;
      req_wr   <= wren;
      req_way  <= vic_way;
    end
    if (fill) begin
      lines[req_way][r_idx] <= mem_rdata;
      tags[req_way][r_idx]  <= r_tag;
    end
    if (wr_hit) lines[hit_way][a_idx][DATA_W*a_word +: DATA_W] <= a_data;
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed and random checks of set_assoc_cache against a transaction-level cache model.
module tb_set_assoc_cache;
  localparam int AW = 32, DW = 32, WAYS = 2, SETS = 256, WORDS = 4, LW = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic interface_ready, rden, wren, data_out_valid;
  logic [AW-1:0] addr_in, mem_addr;
  logic [DW-1:0] data_in, data_out;
  logic mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [LW-1:0] mem_wdata, mem_rdata;

  set_assoc_cache #(.ADDR_W(AW), .DATA_W(DW), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .reset_n(reset_n), .interface_ready(interface_ready), .rden(rden), .wren(wren),
    .addr_in(addr_in), .data_in(data_in), .data_out(data_out), .data_out_valid(data_out_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*DW +: DW] = (a * 32'h9E37_79B1) ^ (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    return l;
  endfunction

  logic [LW-1:0] phys_mem [bit [AW-1:0]];
  logic [LW-1:0] ref_mem  [bit [AW-1:0]];

  function automatic logic [LW-1:0] phys_get(input logic [AW-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_line(a);
  endfunction

  // Line memory: configurable request stall and read latency
  int lat = 1, stall_wb = 0, stall_fetch = 0, stall = 0, cnt = 0;
  bit in_req = 0, pending = 0;
  logic [AW-1:0] pend_addr, cap_addr;
  logic [LW-1:0] cap_wdata;
  logic cap_we;
  logic [AW-1:0] fetch_log[$], wb_addr_log[$];
  logic [LW-1:0] wb_data_log[$];

  initial forever begin
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b0;
    if (mem_req_valid === 1'b1) begin
      if (!in_req) begin
        in_req = 1;
        cap_addr = mem_addr;
        cap_wdata = mem_wdata;
        cap_we = mem_we;
        stall = mem_we ? stall_wb : stall_fetch;
      end else begin
        check("hold_addr", mem_addr, cap_addr);
        check("hold_wdata", mem_wdata, cap_wdata);
        check("hold_we", mem_we, cap_we);
        check("hold_ready", interface_ready, 0);
      end
      if (stall > 0) stall--;
      else begin
        mem_req_ready = 1'b1;
        in_req = 0;
        if (mem_we) begin
          wb_addr_log.push_back(mem_addr);
          wb_data_log.push_back(mem_wdata);
          phys_mem[mem_addr] = mem_wdata;
        end else begin
          fetch_log.push_back(mem_addr);
          pending = 1;
          cnt = lat;
          pend_addr = mem_addr;
        end
      end
    end else in_req = 0;
    if (pending) begin
      if (cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = phys_get(pend_addr);
        pending = 0;
      end else cnt--;
    end
  end

  // Reference cache: per-set ways with valid/dirty/tag/line and a round-robin pointer
  bit m_valid [WAYS][SETS];
  bit m_dirty [WAYS][SETS];
  logic [19:0] m_tag [WAYS][SETS];
  logic [LW-1:0] m_line [WAYS][SETS];
  int m_ptr [SETS];

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
      end
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
  endtask

  task automatic model(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output bit hit,
                       output logic [DW-1:0] rd, output bit wb, output logic [AW-1:0] wba,
                       output logic [LW-1:0] wbd, output logic [AW-1:0] fa);
    int idx = int'(a[11:4]);
    int wd = int'(a[3:2]);
    int way = -1;
    logic [19:0] tg = a[31:12];
    wb = 0; wba = '0; wbd = '0; fa = '0;
    for (int w = 0; w < WAYS; w++) if (m_valid[w][idx] && m_tag[w][idx] == tg) way = w;
    hit = way >= 0;
    if (!hit) begin
      fa = {tg, a[11:4], 4'b0};
      way = m_ptr[idx];
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][idx]) way = w;
      if (m_valid[way][idx] && m_dirty[way][idx]) begin
        wb = 1;
        wba = {m_tag[way][idx], a[11:4], 4'b0};
        wbd = m_line[way][idx];
        ref_mem[wba] = wbd;
      end
      m_line[way][idx] = ref_mem.exists(fa) ? ref_mem[fa] : init_line(fa);
      m_valid[way][idx] = 1;
      m_dirty[way][idx] = 0;
      m_tag[way][idx] = tg;
      m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
    end
    rd = m_line[way][idx][wd*DW +: DW];
    if (wr) begin
      m_line[way][idx][wd*DW +: DW] = d;
      m_dirty[way][idx] = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rden = 1'b0;
    wren = 1'b0;
    in_req = 0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_ready", interface_ready, 1);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_valid", data_out_valid, 0);
    model_reset();
  endtask

  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int cyc);
    bit e_hit, e_wb;
    logic [DW-1:0] e_rd;
    logic [AW-1:0] e_wba, e_fa;
    logic [LW-1:0] e_wbd;
    int nf = fetch_log.size();
    int nw = wb_addr_log.size();
    model(wr, a, d, e_hit, e_rd, e_wb, e_wba, e_wbd, e_fa);
    @(negedge clk);
    rden = !wr;
    wren = wr;
    addr_in = a;
    data_in = d;
    #1;
    check("ready_at_issue", interface_ready, e_hit);
    cyc = 0;
    while (interface_ready !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("req_done", interface_ready, 1);
    if (!wr) begin
      check("rd_valid", data_out_valid, 1);
      check("rd_data", data_out, e_rd);
    end else check("wr_no_valid", data_out_valid, 0);
    check("fetch_count", fetch_log.size() - nf, e_hit ? 0 : 1);
    if (!e_hit && fetch_log.size() > nf) check("fetch_addr", fetch_log[$], e_fa);
    check("wb_count", wb_addr_log.size() - nw, e_wb);
    if (e_wb && wb_addr_log.size() > nw) begin
      check("wb_addr", wb_addr_log[$], e_wba);
      check("wb_data", wb_data_log[$], e_wbd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, nf;
    logic [AW-1:0] a;
    rden = 0; wren = 0; addr_in = '0; data_in = '0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    phys_mem[32'h1230] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    ref_mem[32'h1230] = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    repeat (2) @(negedge clk);
    do_reset();
    lat = 5;
    do_req(0, 32'h1230, 0, cyc);
    check("cold_word0", data_out, 32'hAAAA_AAAA);
    do_req(0, 32'h1230, 0, cyc);
    lat = 1;
    do_req(0, 32'h0000, 0, cyc);
    do_req(0, 32'h1000, 0, cyc);
    do_req(0, 32'h0000, 0, cyc);
    do_req(0, 32'h1000, 0, cyc);
    do_req(0, 32'h2000, 0, cyc);
    do_req(0, 32'h1000, 0, cyc);
    do_req(0, 32'h0000, 0, cyc);
    do_reset();
    do_req(1, 32'h0004, 32'hDEAD_BEEF, cyc);
    do_req(0, 32'h1000, 0, cyc);
    check("lat_clean", cyc, 3);
    do_req(0, 32'h2000, 0, cyc);
    check("lat_dirty", cyc, 4);
    if (wb_addr_log.size() > 0) begin
      check("evict_addr", wb_addr_log[$], 32'h0000);
      check("evict_word1", wb_data_log[$][63:32], 32'hDEAD_BEEF);
    end
    do_req(0, 32'h3000, 0, cyc);
    do_req(1, 32'h0108, 32'h1234_5678, cyc);
    do_req(0, 32'h0108, 0, cyc);
    check("alloc_data", data_out, 32'h1234_5678);
    do_req(0, 32'h1100, 0, cyc);
    do_req(0, 32'h2100, 0, cyc);
    do_reset();
    stall_wb = 7;
    do_req(1, 32'h0040, 32'hCAFE_F00D, cyc);
    do_req(0, 32'h1040, 0, cyc);
    do_req(0, 32'h2040, 0, cyc);
    check("bp_latency", cyc, 11);
    stall_wb = 0;
    do_reset();
    lat = 20;
    nf = fetch_log.size();
    @(negedge clk);
    rden = 1; wren = 0; addr_in = 32'h0000_5670;
    for (int k = 0; k < 50 && fetch_log.size() == nf; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    check("abort_fetched", fetch_log.size() - nf, 1);
    check("abort_wait_req", mem_req_valid, 0);
    check("abort_wait_ready", interface_ready, 0);
    @(negedge clk);
    reset_n = 0; rden = 0;
    @(negedge clk);
    reset_n = 1;
    #1;
    check("abort_rst_ready", interface_ready, 1);
    check("abort_rst_req", mem_req_valid, 0);
    model_reset();
    for (int k = 0; k < 60 && pending; k++) @(negedge clk);
    @(negedge clk);
    #1;
    check("late_rvalid_idle", interface_ready, 1);
    lat = 1;
    do_req(0, 32'h0000_5670, 0, cyc);
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(0, 3);
      stall_wb = $urandom_range(0, 2);
      stall_fetch = $urandom_range(0, 2);
      a = AW'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2));
      do_req(1'($urandom_range(0, 1)), a, $urandom, cyc);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        rden = 0; wren = 0;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
